// File: rtl/axi_mem_subordinate.sv
// axi_mem_subordinate: AXI4 subordinate backed by a byte-writable word memory.
// Ports:
//   aclk, areset        clock (rising edge) and asynchronous active-high reset
//   aw*/awvalid/awready write address channel
//   wdata/wstrb/wlast   write data channel with wvalid/wready handshake
//   bid/bresp           write response channel with bvalid/bready handshake
//   ar*/arvalid/arready read address channel
//   rid/rdata/rresp     read data channel with rlast and rvalid/rready handshake
// Read and write sides are independent FSMs, each with one burst in flight.
module axi_mem_subordinate #(
   parameter int DataWidth          = 32,
   parameter int AddressWidth       = 32,
   parameter int TransactionIdWidth = 8,
   parameter int DepthLog2          = 10
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic [TransactionIdWidth-1:0] awid,
   input  logic [AddressWidth-1:0]       awaddr,
   input  logic [7:0]                    awlen,
   input  logic [2:0]                    awsize,
   input  logic [1:0]                    awburst,
   input  logic                          awvalid,
   output logic                          awready,
   input  logic [DataWidth-1:0]          wdata,
   input  logic [DataWidth/8-1:0]        wstrb,
   input  logic                          wlast,
   input  logic                          wvalid,
   output logic                          wready,
   output logic [TransactionIdWidth-1:0] bid,
   output logic [1:0]                    bresp,
   output logic                          bvalid,
   input  logic                          bready,
   input  logic [TransactionIdWidth-1:0] arid,
   input  logic [AddressWidth-1:0]       araddr,
   input  logic [7:0]                    arlen,
   input  logic [2:0]                    arsize,
   input  logic [1:0]                    arburst,
   input  logic                          arvalid,
   output logic                          arready,
   output logic [TransactionIdWidth-1:0] rid,
   output logic [DataWidth-1:0]          rdata,
   output logic [1:0]                    rresp,
   output logic                          rlast,
   output logic                          rvalid,
   input  logic                          rready
);
   localparam int SB = DataWidth / 8;
   localparam int OB = $clog2(SB);
   localparam int AW = AddressWidth;
   localparam logic [1:0] OKAY = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic {R_IDLE, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   logic [DataWidth-1:0] mem [2**DepthLog2];

   // WRAP bursts are only legal with power-of-two beat counts and aligned starts,
   // so the wrap window is the address with the low log2(total bytes) bits replaced.
   function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [2:0] sz,
                                                input logic [7:0] ln, input logic [1:0] bt);
      logic [AW-1:0] step, inc, mask;
      step = AW'(1) << sz;
      inc  = (a & ~(step - AW'(1))) + step;
      mask = ((AW'(ln) + AW'(1)) << sz) - AW'(1);
      return bt == 2'b00 ? a : bt == 2'b10 ? (a & ~mask) | (inc & mask) : inc;
   endfunction

   function automatic logic burst_bad(input logic [AW-1:0] a, input logic [2:0] sz,
                                      input logic [7:0] ln, input logic [1:0] bt);
      return bt == 2'b11 || int'(sz) > OB ||
             (bt == 2'b10 && !(ln inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
             (bt == 2'b10 && (a & ((AW'(1) << sz) - AW'(1))) != '0);
   endfunction

   function automatic logic oor(input logic [AW-1:0] a);
      return (a >> (DepthLog2 + OB)) != '0;
   endfunction

   function automatic logic [DepthLog2-1:0] idx(input logic [AW-1:0] a);
      return DepthLog2'(a >> OB);
   endfunction

   r_state_t                r_state;
   logic [AW-1:0]           r_addr, r_beat;
   logic [7:0]              r_len, r_cnt;
   logic [2:0]              r_size;
   logic [1:0]              r_burst;
   logic                    r_berr, r_bad;
   logic [DataWidth-1:0]    r_word;

   // Beat about to be presented: the AR start address when idle, else the successor.
   // Sampling mem here alongside a same-edge write yields the pre-write word.
   always_comb begin
      r_beat = r_state == R_IDLE ? araddr : next_addr(r_addr, r_size, r_len, r_burst);
      r_bad  = (r_state == R_IDLE ? burst_bad(araddr, arsize, arlen, arburst) : r_berr) || oor(r_beat);
      r_word = r_bad ? '0 : mem[idx(r_beat)];
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state <= R_IDLE;
         arready <= 1'b0;
         rvalid  <= 1'b0;
         rlast   <= 1'b0;
         rid     <= '0;
         rdata   <= '0;
         rresp   <= OKAY;
         r_addr  <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_size  <= '0;
         r_burst <= '0;
         r_berr  <= 1'b0;
      end else if (r_state == R_IDLE) begin
         arready <= 1'b1;
         if (arvalid && arready) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rid     <= arid;
            r_addr  <= araddr;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_berr  <= burst_bad(araddr, arsize, arlen, arburst);
            r_cnt   <= '0;
            rlast   <= arlen == 8'd0;
            rdata   <= r_word;
            rresp   <= r_bad ? SLVERR : OKAY;
            r_state <= R_DATA;
         end
      end else if (rready) begin
         if (rlast) begin
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            arready <= 1'b1;
            r_state <= R_IDLE;
         end else begin
            r_addr <= r_beat;
            r_cnt  <= r_cnt + 8'd1;
            rlast  <= r_cnt + 8'd1 == r_len;
            rdata  <= r_word;
            rresp  <= r_bad ? SLVERR : OKAY;
         end
      end
   end

   w_state_t      w_state;
   logic [AW-1:0] w_addr;
   logic [7:0]    w_len, w_cnt;
   logic [2:0]    w_size;
   logic [1:0]    w_burst;
   logic          w_berr, w_err, w_hs, w_beat_bad, w_we, w_err_next;

   // A burst-level error suppresses every write; an out-of-range beat only its own.
   // wlast disagreeing with the beat count only taints the response.
   always_comb begin
      w_hs       = w_state == W_DATA && wvalid && wready;
      w_beat_bad = oor(w_addr);
      w_we       = w_hs && !w_berr && !w_beat_bad;
      w_err_next = w_err || w_berr || w_beat_bad || (wlast != (w_cnt == w_len));
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         w_state <= W_IDLE;
         awready <= 1'b0;
         wready  <= 1'b0;
         bvalid  <= 1'b0;
         bid     <= '0;
         bresp   <= OKAY;
         w_addr  <= '0;
         w_len   <= '0;
         w_cnt   <= '0;
         w_size  <= '0;
         w_burst <= '0;
         w_berr  <= 1'b0;
         w_err   <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               awready <= 1'b1;
               if (awvalid && awready) begin
                  awready <= 1'b0;
                  wready  <= 1'b1;
                  bid     <= awid;
                  w_addr  <= awaddr;
                  w_len   <= awlen;
                  w_size  <= awsize;
                  w_burst <= awburst;
                  w_berr  <= burst_bad(awaddr, awsize, awlen, awburst);
                  w_err   <= 1'b0;
                  w_cnt   <= '0;
                  w_state <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_hs) begin
                  w_err <= w_err_next;
                  if (w_cnt == w_len) begin
                     wready  <= 1'b0;
                     bvalid  <= 1'b1;
                     bresp   <= w_err_next ? SLVERR : OKAY;
                     w_state <= W_RESP;
                  end else begin
                     w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
                     w_cnt  <= w_cnt + 8'd1;
                  end
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid  <= 1'b0;
                  awready <= 1'b1;
                  w_state <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Storage is deliberately outside the reset domain so reset leaves contents intact.
   always_ff @(posedge aclk) begin
      if (w_we)
         for (int b = 0; b < SB; b++)
            if (wstrb[b]) mem[idx(w_addr)][8*b +: 8] <= wdata[8*b +: 8];
   end
endmodule

// File: doc/axi_mem_subordinate.md
AXI_MEM_SUBORDINATE -- requirements
Module: axi_mem_subordinate
Interface
REQ-001 DataWidth, 32, data bus width in bits; 32, 64 or 128.
REQ-002 AddressWidth, 32, byte address width.
REQ-003 TransactionIdWidth, 8, AXI ID width.
REQ-004 DepthLog2, 10, log2 of backing-memory depth in DataWidth words.
REQ-005 aclk in 1 clock; all logic on rising edge.
REQ-006 areset in 1 reset; asynchronous, active-high.
REQ-007 awid in TransactionIdWidth write ID.
REQ-008 awaddr in AddressWidth write start address.
REQ-009 awlen in 8 write beats minus one.
REQ-010 awsize in 3 write bytes-per-beat log2.
REQ-011 awburst in 2 write burst type.
REQ-012 awvalid in 1 / awready out 1: AW handshake.
REQ-013 wdata in DataWidth write data.
REQ-014 wstrb in DataWidth/8 byte strobes.
REQ-015 wlast in 1 last write beat.
REQ-016 wvalid in 1 / wready out 1: W handshake.
REQ-017 bid out TransactionIdWidth response ID.
REQ-018 bresp out 2 write response.
REQ-019 bvalid out 1 / bready in 1: B handshake.
REQ-020 arid in TransactionIdWidth read ID.
REQ-021 araddr in AddressWidth read start address.
REQ-022 arlen in 8 read beats minus one.
REQ-023 arsize in 3 read bytes-per-beat log2.
REQ-024 arburst in 2 read burst type.
REQ-025 arvalid in 1 / arready out 1: AR handshake.
REQ-026 rid out TransactionIdWidth read ID.
REQ-027 rdata out DataWidth read data.
REQ-028 rresp out 2 read response.
REQ-029 rlast out 1 last read beat.
REQ-030 rvalid out 1 / rready in 1: R handshake.
Function
REQ-031 Memory: 2**DepthLog2 words, uninitialised; word index = address bits [DepthLog2+log2(DataWidth/8)-1 : log2(DataWidth/8)]; byte address >= (2**DepthLog2)*(DataWidth/8) is out of range.
REQ-032 Read FSM R_IDLE/R_DATA, write FSM W_IDLE/W_DATA/W_RESP, fully independent; one outstanding transaction per direction; arready=1 only in R_IDLE, awready=1 only in W_IDLE.
REQ-033 Beat address: FIXED (00) constant; INCR (01) = previous address aligned down to 2**size plus 2**size; WRAP (10) same but wraps to floor(start/((len+1)*2**size))*((len+1)*2**size) at that boundary; 4 KB crossings not checked.
REQ-034 Burst error (whole burst SLVERR=2'b10): burst type 11; WRAP with len not in {1,3,7,15}; size > log2(DataWidth/8); WRAP start not aligned to 2**size; all beats still transferred, data discarded/returned as 0.
REQ-035 Per-beat error: out-of-range beat gives SLVERR for that beat (read, rdata=0) or marks burst (write, no memory update); otherwise OKAY=2'b00.
REQ-036 Read: AR handshake at edge N -> rvalid=1 from edge N+1 with rid=arid, full word at beat address; each R handshake advances one beat, next beat valid next cycle (1 beat/cycle if rready held); rlast=1 on beat len; after last handshake return to R_IDLE, arready=1 next cycle.
REQ-037 Write: AW handshake -> W_DATA, wready=1; each W handshake writes bytes where wstrb=1 (unaligned/narrow beats rely on master strobes); after beat len -> W_RESP, bvalid=1 next cycle, bid=awid, held with bid/bresp stable until bready.
REQ-038 wlast mismatch (wlast=1 before beat len, or 0 on beat len): beat count governs, bresp=SLVERR, no other effect.
REQ-039 rvalid/bvalid, once high, stay high with payload stable until accepted.
REQ-040 Same-cycle read and write of one word: read returns pre-write data.
Reset
REQ-041 areset asserted (any time, incl. mid-burst): both FSMs to idle, all outputs 0 including readys, in-flight bursts abandoned, memory untouched; arready/awready=1 on first edge after release.
Verification
REQ-042 INCR write awaddr=0x10, len=3, size=2, data 1..4, wstrb=F -> bresp OKAY; INCR read same -> rdata 1,2,3,4, rlast on 4th, rresp OKAY.
REQ-043 WRAP read araddr=0x18, len=3, size=2 after REQ-042 -> addresses 0x18,0x1C,0x10,0x14, data 3,4,1,2.
REQ-044 Write wstrb=4'b0010 data 0xAABBCCDD to word of 0x11223344 -> reads 0x1122CC44; out-of-range write -> SLVERR, memory unchanged.
REQ-045 arburst=11 len=1 -> two beats rresp SLVERR, rdata 0; rready low 5 cycles mid-burst -> rdata/rlast stable.
REQ-046 areset pulse during beat 2 of 4-beat write -> bvalid/wready 0, awready 1 after release; new write completes OKAY.
